// File: rtl/if_pkg.sv
// Shared types and constants for the RV64 instruction fetch stage.
package if_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            filled;
    logic            fault;
  } fetch_slot_t;

endpackage

// File: rtl/fetch_fifo.sv
// Reservation ring buffer: slots are reserved at request time and filled in
// order by memory responses; flush clears state and can preload one slot.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       load,
  input  fetch_slot_t                load_slot,
  input  logic                       reserve,
  input  logic [XLEN-1:0]            reserve_pc,
  input  logic                       fill,
  input  logic [ILEN-1:0]            fill_inst,
  input  logic                       pop,
  output fetch_slot_t                head,
  output logic [$clog2(DEPTH+1)-1:0] used,
  output logic [$clog2(DEPTH+1)-1:0] pending
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_slot_t   slots [DEPTH];
  logic [PW-1:0] alloc_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] head_ptr;

  assign head = slots[head_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) slots[PW'(i)] <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      used      <= '0;
      pending   <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slots[PW'(i)].filled <= 1'b0;
        slots[PW'(i)].fault  <= 1'b0;
      end
      head_ptr <= '0;
      pending  <= '0;
      // Preloaded slot 0 counts as already reserved and filled.
      if (load) begin
        slots[0]  <= load_slot;
        alloc_ptr <= PW'(1);
        fill_ptr  <= PW'(1);
        used      <= CW'(1);
      end else begin
        alloc_ptr <= '0;
        fill_ptr  <= '0;
        used      <= '0;
      end
    end else begin
      if (reserve) begin
        slots[alloc_ptr] <= '{pc: reserve_pc, inst: '0, filled: 1'b0, fault: 1'b0};
        alloc_ptr        <= alloc_ptr + 1'b1;
      end
      if (fill) begin
        slots[fill_ptr].inst   <= fill_inst;
        slots[fill_ptr].filled <= 1'b1;
        fill_ptr               <= fill_ptr + 1'b1;
      end
      if (pop) head_ptr <= head_ptr + 1'b1;
      used    <= used + CW'(reserve) - CW'(pop);
      pending <= pending + CW'(reserve) - CW'(fill);
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: PC, in-order imem requests, stale-response drop
// counter and decoder handshake. IF_ALIGN_CHECK_EN enables misaligned-redirect faults.
module if_fetch
  import if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic            inst_fault
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned DW = $clog2(2 * DEPTH + 1);

  logic [XLEN-1:0] pc;
  logic [DW-1:0]   drop;
  logic            halted;
  logic            misaligned;
  logic [XLEN-1:0] target;
  fetch_slot_t     head;
  fetch_slot_t     load_slot;
  logic [CW-1:0]   used;
  logic [CW-1:0]   pending;
  logic            pop;
  logic            accept;
  logic            fill;

`ifdef IF_ALIGN_CHECK_EN
  assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign target     = redirect_pc;
  assign inst_fault = head.fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              halted <= 1'b0;
    else if (redirect_valid) halted <= misaligned;
  end
`else
  logic unused_bits;
  assign unused_bits = ^{head.fault, redirect_pc[1:0]};
  assign misaligned  = 1'b0;
  assign target      = {redirect_pc[XLEN-1:2], 2'b00};
  assign halted      = 1'b0;
`endif

  assign inst_valid = (used != '0) && head.filled;
  assign inst       = head.inst;
  assign inst_pc    = head.pc;
  assign pop        = inst_valid && inst_ready;

  // A same-cycle pop frees a slot, keeping full-rate fetch with DEPTH slots.
  assign imem_req_valid = rst_n && !redirect_valid && !halted && ((used < CW'(DEPTH)) || pop);
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign fill           = imem_resp_valid && (drop == '0) && !redirect_valid;
  assign load_slot      = '{pc: redirect_pc, inst: NOP_INST, filled: 1'b1, fault: 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc   <= RESET_PC;
      drop <= '0;
    end else if (redirect_valid) begin
      pc   <= target;
      // A response arriving now retires one outstanding request either way.
      drop <= drop + DW'(pending) - DW'(imem_resp_valid);
    end else begin
      if (accept) pc <= pc + XLEN'(4);
      if (imem_resp_valid && (drop != '0)) drop <= drop - 1'b1;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .load       (misaligned),
    .load_slot  (load_slot),
    .reserve    (accept),
    .reserve_pc (pc),
    .fill       (fill),
    .fill_inst  (imem_resp_data),
    .pop        (pop),
    .head       (head),
    .used       (used),
    .pending    (pending)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with an in-order, fixed-latency memory model.
module tb_if_fetch;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst;
  logic [63:0] inst_pc;
`ifdef IF_ALIGN_CHECK_EN
  logic        inst_fault;
`endif

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(64'h0), .DEPTH(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc)
`ifdef IF_ALIGN_CHECK_EN
    ,
    .inst_fault      (inst_fault)
`endif
  );

  typedef struct {
    logic [63:0] addr;
    int unsigned due;
  } mreq_t;

  mreq_t       mq[$];
  logic [63:0] acc_q[$];
  logic [63:0] pop_pc_q[$];
  logic [31:0] pop_inst_q[$];
  int unsigned cyc = 0;
  int unsigned lat = 1;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, advance the memory model after.
  task automatic tick();
    logic        acc;
    logic        rv;
    logic [63:0] a;
    #1;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    rv  = imem_resp_valid;
    if (inst_valid && inst_ready) begin
      pop_pc_q.push_back(inst_pc);
      pop_inst_q.push_back(inst);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rv && mq.size() > 0) mq.delete(0);
    if (acc) begin
      mq.push_back('{addr: a, due: cyc + lat - 1});
      acc_q.push_back(a);
    end
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    mq.delete();
    acc_q.delete();
    pop_pc_q.delete();
    pop_inst_q.delete();
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    @(posedge clk);
    #1;
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    rst_n = 1'b1;
    #1;
    check("rel_req_valid", imem_req_valid, 1);
    check("rel_req_addr", imem_req_addr, 64'h0);
  endtask

  task automatic wait_inst(input string tag, output int n);
    n = 0;
    while (!inst_valid && n < 20) begin
      tick();
      n++;
    end
    check(tag, inst_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int k;
    logic [63:0] hold;
    logic chk;

    // Streaming at latency 1
    lat = 1; inst_ready = 1; imem_req_ready = 1;
    do_reset();
    tick();
    check("s_iv0", inst_valid, 0);
    check("s_addr1", imem_req_addr, 64'h4);
    tick();
    check("s_iv1", inst_valid, 1);
    check("s_pc0", inst_pc, 64'h0);
    check("s_inst0", inst, mem_word(64'h0));
    check("s_addr2", imem_req_addr, 64'h8);
    check("s_rv2", imem_req_valid, 1);
    tick();
    check("s_pc1", inst_pc, 64'h4);
    check("s_addr3", imem_req_addr, 64'hC);
    tick();
    check("s_pc2", inst_pc, 64'h8);

    // Decoder stall: only DEPTH requests accepted
    inst_ready = 0;
    do_reset();
    tick();
    tick();
    check("st_rv_full", imem_req_valid, 0);
    check("st_pc0", inst_pc, 64'h0);
    repeat (3) tick();
    check("st_acc_cnt", acc_q.size(), 2);
    check("st_rv_hold", imem_req_valid, 0);
    check("st_addr", imem_req_addr, 64'h8);
    inst_ready = 1;
    #1;
    check("st_rv_pop", imem_req_valid, 1);
    tick();
    check("st_pc1", inst_pc, 64'h4);
    check("st_inst1", inst, mem_word(64'h4));
    inst_ready = 0;
    #1;
    check("st_rv_full2", imem_req_valid, 0);

    // Redirect with two requests in flight at latency 3
    lat = 3; inst_ready = 1;
    do_reset();
    tick();
    tick();
    check("rd_rv_full", imem_req_valid, 0);
    redirect_valid = 1; redirect_pc = 64'h100;
    #1;
    check("rd_rv_redir", imem_req_valid, 0);
    tick();
    redirect_valid = 0;
    #1;
    check("rd_rv_r1", imem_req_valid, 1);
    check("rd_addr_r1", imem_req_addr, 64'h100);
    wait_inst("rd_timeout", n);
    check("rd_lat", n, 4);
    check("rd_pc", inst_pc, 64'h100);
    check("rd_inst", inst, mem_word(64'h100));
    tick();
    check("rd_pc_next", inst_pc, 64'h104);
    check("rd_pop_cnt", pop_pc_q.size(), 1);
    if (pop_pc_q.size() > 0) check("rd_pop_pc", pop_pc_q[0], 64'h100);

    // Redirect coincident with a response and a pop
    lat = 1; inst_ready = 1;
    do_reset();
    tick();
    tick();
    redirect_valid = 1; redirect_pc = 64'h200;
    tick();
    redirect_valid = 0;
    check("co_pop_cnt", pop_pc_q.size(), 1);
    if (pop_pc_q.size() > 0) begin
      check("co_pop_pc", pop_pc_q[0], 64'h0);
      check("co_pop_inst", pop_inst_q[0], mem_word(64'h0));
    end
    #1;
    check("co_empty", inst_valid, 0);
    check("co_addr", imem_req_addr, 64'h200);
    wait_inst("co_timeout", n);
    check("co_lat", n, 2);
    check("co_pc", inst_pc, 64'h200);

    // Toggling request ready at latency 2
    lat = 2; inst_ready = 1;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      imem_req_ready = (i % 3 != 1);
      #1;
      chk  = imem_req_valid && !imem_req_ready;
      hold = imem_req_addr;
      tick();
      if (chk) check("tg_hold", imem_req_addr, hold);
    end
    imem_req_ready = 0;
    repeat (6) tick();
    check("tg_cnt", pop_pc_q.size(), acc_q.size());
    k = 0;
    foreach (acc_q[j]) begin
      check("tg_acc", acc_q[j], 64'(4 * j));
      k++;
    end
    check("tg_acc_n", k, 10);
    foreach (pop_pc_q[j]) begin
      check("tg_pop_pc", pop_pc_q[j], 64'(4 * j));
      check("tg_pop_inst", pop_inst_q[j], mem_word(64'(4 * j)));
    end
    imem_req_ready = 1;

    // Misaligned redirect
    lat = 1; inst_ready = 1;
    do_reset();
    tick();
    tick();
`ifdef IF_ALIGN_CHECK_EN
    redirect_valid = 1; redirect_pc = 64'h102; inst_ready = 0;
    tick();
    redirect_valid = 0;
    #1;
    check("ft_iv", inst_valid, 1);
    check("ft_fault", inst_fault, 1);
    check("ft_pc", inst_pc, 64'h102);
    check("ft_inst", inst, 64'h13);
    check("ft_rv", imem_req_valid, 0);
    k = acc_q.size();
    repeat (3) tick();
    check("ft_rv_hold", imem_req_valid, 0);
    inst_ready = 1;
    tick();
    check("ft_popped", inst_valid, 0);
    repeat (2) tick();
    check("ft_no_req", acc_q.size(), k);
    redirect_valid = 1; redirect_pc = 64'h200;
    tick();
    redirect_valid = 0;
    #1;
    check("ft_rv_resume", imem_req_valid, 1);
    check("ft_addr_resume", imem_req_addr, 64'h200);
    wait_inst("ft_timeout", n);
    check("ft_pc_resume", inst_pc, 64'h200);
    check("ft_fault_clr", inst_fault, 0);
`else
    redirect_valid = 1; redirect_pc = 64'h102;
    tick();
    redirect_valid = 0;
    #1;
    check("al_addr", imem_req_addr, 64'h100);
    wait_inst("al_timeout", n);
    check("al_pc", inst_pc, 64'h100);
    check("al_inst", inst, mem_word(64'h100));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
